// File: rtl/ll8_tx_arbiter_pkg.sv
// Shared definitions for the ll8 TX arbiter: FSM state encoding, default
// frame limits, the ll8 beat bundle and the arbitration pick helpers.
package ll8_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Largest untagged Ethernet frame in bytes; one ll8 beat carries one byte.
  localparam int DEFAULT_MAX_LEN   = 1518;
  localparam int DEFAULT_LEN_WIDTH = 11;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    logic       error;
  } ll8_beat_t;

  // Winning port index for a set of sof requests. The caller only uses the
  // result when at least one port requests.
  function automatic logic pick_winner(input logic req0, input logic req1,
                                       input logic prio_mode, input logic last_grant);
    if (req0 && req1) begin
      return prio_mode ? 1'b0 : ~last_grant;
    end
    return req1;
  endfunction

  // One-hot grant vector for a port index.
  function automatic logic [1:0] grant_of(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ll8_tx_arbiter.sv
// Packet-granular 2:1 arbiter in front of the ll8 TX path. Port 0 carries
// control/pause responses, port 1 host data. Whole packets are granted
// sof..eof, over-long packets are truncated with error, and beats arriving
// without a preceding sof while idle are discarded.
module ll8_tx_arbiter
  import ll8_tx_arbiter_pkg::*;
#(
  parameter int MAX_LEN   = DEFAULT_MAX_LEN,
  parameter int LEN_WIDTH = DEFAULT_LEN_WIDTH
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       prio_mode,
  input  logic [7:0] in0_data,
  input  logic       in0_sof,
  input  logic       in0_eof,
  input  logic       in0_error,
  input  logic       in0_src_rdy,
  output logic       in0_dst_rdy,
  input  logic [7:0] in1_data,
  input  logic       in1_sof,
  input  logic       in1_eof,
  input  logic       in1_error,
  input  logic       in1_src_rdy,
  output logic       in1_dst_rdy,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       out_eof,
  output logic       out_error,
  output logic       out_src_rdy,
  input  logic       out_dst_rdy,
  output logic [1:0] grant,
  output logic       busy,
  output logic       trunc_pulse,
  output logic       orphan_pulse
);

  // Index of the final permitted beat; the counter holds beats already sent.
  localparam logic [LEN_WIDTH-1:0] LAST_IDX = LEN_WIDTH'(MAX_LEN - 1);

  state_t               state;
  logic                 sel;
  logic                 last_grant;
  logic [LEN_WIDTH-1:0] count;

  ll8_beat_t in0_beat;
  ll8_beat_t in1_beat;
  ll8_beat_t sel_beat;
  logic      sel_src_rdy;
  logic      active;
  logic      req0;
  logic      req1;
  logic      winner;
  logic      sel_xfer;
  logic      at_limit;
  logic      trunc;
  logic      drain_done;

  assign in0_beat = '{data: in0_data, sof: in0_sof, eof: in0_eof, error: in0_error};
  assign in1_beat = '{data: in1_data, sof: in1_sof, eof: in1_eof, error: in1_error};

  assign sel_beat    = sel ? in1_beat : in0_beat;
  assign sel_src_rdy = sel ? in1_src_rdy : in0_src_rdy;

  // Clear squashes every handshake in the cycle it is asserted, just like reset.
  assign active = reset_n & ~clear;

  assign req0   = in0_src_rdy & in0_sof;
  assign req1   = in1_src_rdy & in1_sof;
  assign winner = pick_winner(req0, req1, prio_mode, last_grant);

  assign sel_xfer   = active & (state == ST_XFER) & sel_src_rdy & out_dst_rdy;
  assign at_limit   = (count == LAST_IDX);
  assign trunc      = sel_xfer & ~sel_beat.eof & at_limit;
  assign drain_done = active & (state == ST_DRAIN) & sel_src_rdy & sel_beat.eof;

  // Handshake steering and output pass-through for the current state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
    out_data     = '0;
    out_sof      = 1'b0;
    out_eof      = 1'b0;
    out_error    = 1'b0;
    out_src_rdy  = 1'b0;
    in0_dst_rdy  = 1'b0;
    in1_dst_rdy  = 1'b0;
    trunc_pulse  = 1'b0;
    orphan_pulse = 1'b0;
    if (active) begin
      unique case (state)
        ST_IDLE: begin
          // Sof beats wait for the grant; anything else is an orphan and is eaten.
          in0_dst_rdy  = in0_src_rdy & ~in0_sof;
          in1_dst_rdy  = in1_src_rdy & ~in1_sof;
          orphan_pulse = (in0_src_rdy & ~in0_sof) | (in1_src_rdy & ~in1_sof);
        end
        ST_XFER: begin
          out_data    = sel_beat.data;
          out_sof     = sel_beat.sof;
          out_eof     = sel_beat.eof | trunc;
          out_error   = sel_beat.error | trunc;
          out_src_rdy = sel_src_rdy;
          trunc_pulse = trunc;
          if (sel) in1_dst_rdy = out_dst_rdy;
          else     in0_dst_rdy = out_dst_rdy;
        end
        ST_DRAIN: begin
          if (sel) in1_dst_rdy = 1'b1;
          else     in0_dst_rdy = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Grant FSM: pick a packet owner, count its beats, release on eof or drain.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state      <= ST_IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      count      <= '0;
      grant      <= 2'b00;
      busy       <= 1'b0;
    end else if (clear) begin
      state      <= ST_IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      count      <= '0;
      grant      <= 2'b00;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (enable && (req0 || req1)) begin
            state <= ST_XFER;
            sel   <= winner;
            grant <= grant_of(winner);
            busy  <= 1'b1;
            count <= '0;
          end
        end
        ST_XFER: begin
          if (sel_xfer) begin
            if (sel_beat.eof) begin
              state      <= ST_IDLE;
              last_grant <= sel;
              grant      <= 2'b00;
              busy       <= 1'b0;
              count      <= '0;
            end else if (at_limit) begin
              state <= ST_DRAIN;
              count <= '0;
            end else begin
              count <= count + LEN_WIDTH'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state      <= ST_IDLE;
            last_grant <= sel;
            grant      <= 2'b00;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ll8_tx_arbiter.sv
// Self-checking bench for ll8_tx_arbiter. Packets are described by port,
// length and data base; a packet-level model turns each description into the
// beats the output must carry (with truncation at MAX_LEN), and a monitor
// compares every output transfer against that expected stream.
module tb_ll8_tx_arbiter;

  localparam int MAX = 128;
  localparam int LW  = 8;

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    logic       err;
  } in_beat_t;

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    logic       err;
    logic       trunc;
    logic       port;
  } exp_beat_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       enable;
  logic       prio_mode;
  logic [7:0] in0_data, in1_data;
  logic       in0_sof, in0_eof, in0_error, in0_src_rdy, in0_dst_rdy;
  logic       in1_sof, in1_eof, in1_error, in1_src_rdy, in1_dst_rdy;
  logic [7:0] out_data;
  logic       out_sof, out_eof, out_error, out_src_rdy;
  logic       out_dst_rdy;
  logic [1:0] grant;
  logic       busy, trunc_pulse, orphan_pulse;

  in_beat_t  q0[$];
  in_beat_t  q1[$];
  exp_beat_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int out_beats = 0;
  int orph_cnt = 0;
  int trunc_cnt = 0;
  int rdy_mode = 1;  // 0: stall, 1: always ready, 2: random

  ll8_tx_arbiter #(.MAX_LEN(MAX), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable), .prio_mode(prio_mode),
    .in0_data(in0_data), .in0_sof(in0_sof), .in0_eof(in0_eof), .in0_error(in0_error),
    .in0_src_rdy(in0_src_rdy), .in0_dst_rdy(in0_dst_rdy),
    .in1_data(in1_data), .in1_sof(in1_sof), .in1_eof(in1_eof), .in1_error(in1_error),
    .in1_src_rdy(in1_src_rdy), .in1_dst_rdy(in1_dst_rdy),
    .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof), .out_error(out_error),
    .out_src_rdy(out_src_rdy), .out_dst_rdy(out_dst_rdy),
    .grant(grant), .busy(busy), .trunc_pulse(trunc_pulse), .orphan_pulse(orphan_pulse)
  );

  always #4 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Queue a packet on a source port.
  task automatic send(input int port, input int len, input int base, input bit err_last);
    in_beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = 8'(base + i);
      b.sof  = (i == 0);
      b.eof  = (i == len - 1);
      b.err  = err_last && (i == len - 1);
      if (port == 0) q0.push_back(b);
      else           q1.push_back(b);
    end
  endtask

  // Model: what the output must carry for a packet of this description.
  task automatic exp_pkt(input int port, input int len, input int base, input bit err_last);
    exp_beat_t e;
    int n;
    n = (len > MAX) ? MAX : len;
    for (int i = 0; i < n; i++) begin
      e.data  = 8'(base + i);
      e.sof   = (i == 0);
      e.port  = (port != 0);
      if (len > MAX && i == MAX - 1) begin
        e.eof = 1'b1; e.err = 1'b1; e.trunc = 1'b1;
      end else begin
        e.eof = (i == len - 1); e.err = err_last && (i == len - 1); e.trunc = 1'b0;
      end
      exp_q.push_back(e);
    end
  endtask

  // Source driver for both ports: hold a beat until it is accepted.
  initial begin
    logic acc0, acc1;
    in0_data = '0; in0_sof = 0; in0_eof = 0; in0_error = 0; in0_src_rdy = 0;
    in1_data = '0; in1_sof = 0; in1_eof = 0; in1_error = 0; in1_src_rdy = 0;
    forever begin
      @(negedge clk);
      acc0 = in0_src_rdy & in0_dst_rdy;
      acc1 = in1_src_rdy & in1_dst_rdy;
      @(posedge clk);
      #1;
      if (acc0) void'(q0.pop_front());
      if (acc1) void'(q1.pop_front());
      if (q0.size() > 0) begin
        in0_data = q0[0].data; in0_sof = q0[0].sof; in0_eof = q0[0].eof;
        in0_error = q0[0].err; in0_src_rdy = 1'b1;
      end else begin
        in0_data = '0; in0_sof = 0; in0_eof = 0; in0_error = 0; in0_src_rdy = 0;
      end
      if (q1.size() > 0) begin
        in1_data = q1[0].data; in1_sof = q1[0].sof; in1_eof = q1[0].eof;
        in1_error = q1[0].err; in1_src_rdy = 1'b1;
      end else begin
        in1_data = '0; in1_sof = 0; in1_eof = 0; in1_error = 0; in1_src_rdy = 0;
      end
    end
  end

  // Downstream ready pattern.
  initial begin
    out_dst_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_dst_rdy = 1'b0;
        1:       out_dst_rdy = 1'b1;
        default: out_dst_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare every output transfer against the model stream.
  initial begin
    exp_beat_t e;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        check("grant_legal", 32'(grant != 2'b11), 32'd1);
        check("busy_vs_grant", 32'(busy), 32'(grant != 2'b00));
        if (out_src_rdy && out_dst_rdy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", {24'd0, out_data}, 32'hffff_ffff);
          end else begin
            e = exp_q.pop_front();
            check("beat", 32'({out_data, out_sof, out_eof, out_error}),
                  32'({e.data, e.sof, e.eof, e.err}));
            check("beat_grant", 32'(grant), 32'(e.port ? 2'b10 : 2'b01));
            check("beat_trunc", 32'(trunc_pulse), 32'(e.trunc));
          end
          out_beats++;
        end else begin
          check("trunc_quiet", 32'(trunc_pulse), 32'd0);
        end
        if (orphan_pulse) orph_cnt++;
        if (trunc_pulse)  trunc_cnt++;
      end
    end
  end

  // Wait until the model stream is drained and the arbiter is idle.
  task automatic wait_idle(input int budget, input bit need_q);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && busy == 1'b0 &&
             (!need_q || (q0.size() == 0 && q1.size() == 0)))) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        check("timeout", 32'(n), 32'(budget));
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, o0;
    reset_n = 1'b0; clear = 1'b0; enable = 1'b1; prio_mode = 1'b0;

    // Reset: outputs low even while an orphan beat is presented.
    q0.push_back('{data: 8'h5a, sof: 1'b0, eof: 1'b0, err: 1'b0});
    repeat (3) @(negedge clk);
    check("rst_in0_dst_rdy", 32'(in0_dst_rdy), 32'd0);
    check("rst_orphan", 32'(orphan_pulse), 32'd0);
    check("rst_out_src_rdy", 32'(out_src_rdy), 32'd0);
    check("rst_out_flags", 32'({out_sof, out_eof, out_error, trunc_pulse}), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_grant_busy", 32'({grant, busy}), 32'd0);
    reset_n = 1'b1;
    wait_idle(20, 1);
    check("rst_orphan_after", 32'(orph_cnt), 32'd1);

    // Port 1 alone, 60 beats; first beat one cycle after the request.
    send(1, 60, 8'h00, 1'b0);
    exp_pkt(1, 60, 8'h00, 1'b0);
    @(negedge clk);
    check("lat_idle_busy", 32'(busy), 32'd0);
    check("lat_idle_out", 32'(out_src_rdy), 32'd0);
    check("lat_sof_held", 32'(in1_dst_rdy), 32'd0);
    @(negedge clk);
    check("lat_grant", 32'(grant), 32'h2);
    check("lat_first", 32'({out_src_rdy, out_sof, out_data}), 32'h300);
    wait_idle(200, 1);

    // Round-robin after reset: both request, 3 x 64 beats each.
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      send(0, 64, 8'h10 * k, 1'b0);
      send(1, 64, 8'h80 + 8'h10 * k, k == 1);
    end
    for (int k = 0; k < 3; k++) begin
      exp_pkt(0, 64, 8'h10 * k, 1'b0);
      exp_pkt(1, 64, 8'h80 + 8'h10 * k, k == 1);
    end
    wait_idle(1000, 1);

    // Strict priority: port 0 streams three packets, port 1 waits.
    prio_mode = 1'b1;
    send(1, 20, 8'hc0, 1'b0);
    for (int k = 0; k < 3; k++) send(0, 20, 8'h20 * k, 1'b0);
    for (int k = 0; k < 3; k++) exp_pkt(0, 20, 8'h20 * k, 1'b0);
    exp_pkt(1, 20, 8'hc0, 1'b0);
    wait_idle(400, 1);
    prio_mode = 1'b0;

    // Exactly MAX beats is legal; MAX+4 truncates; the next packet is clean.
    send(0, MAX, 8'h00, 1'b0);
    send(1, MAX + 4, 8'h40, 1'b0);
    send(1, 5, 8'he0, 1'b0);
    exp_pkt(0, MAX, 8'h00, 1'b0);
    exp_pkt(1, MAX + 4, 8'h40, 1'b0);
    exp_pkt(1, 5, 8'he0, 1'b0);
    wait_idle(800, 1);
    check("trunc_count", 32'(trunc_cnt), 32'd1);

    // Three orphans, then a single-beat packet and a 6-beat packet.
    o0 = orph_cnt;
    for (int k = 0; k < 3; k++) q0.push_back('{data: 8'(k), sof: 1'b0, eof: 1'b0, err: 1'b0});
    send(0, 1, 8'h77, 1'b0);
    send(0, 6, 8'h30, 1'b0);
    exp_pkt(0, 1, 8'h77, 1'b0);
    exp_pkt(0, 6, 8'h30, 1'b0);
    wait_idle(100, 1);
    check("orphan_count", 32'(orph_cnt - o0), 32'd3);

    // Clear mid-packet while stalled; packet is then re-arbitrated and sent.
    rdy_mode = 0;
    send(0, 10, 8'h40, 1'b0);
    repeat (3) @(negedge clk);
    check("clr_pre_grant", 32'({grant, busy}), 32'h3);
    check("clr_pre_stall", 32'({out_src_rdy, in0_dst_rdy}), 32'h2);
    rdy_mode = 1;
    @(posedge clk);
    #1 clear = 1'b1;
    @(negedge clk);
    check("clr_gated", 32'({out_src_rdy, in0_dst_rdy, orphan_pulse}), 32'd0);
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check("clr_state", 32'({grant, busy}), 32'd0);
    exp_pkt(0, 10, 8'h40, 1'b0);
    wait_idle(100, 1);

    // Random backpressure on a 100-beat packet with enable dropped mid-packet.
    rdy_mode = 2;
    send(1, 100, 8'h80, 1'b0);
    exp_pkt(1, 100, 8'h80, 1'b0);
    start = out_beats;
    for (int n = 0; n < 1000 && out_beats < start + 10; n++) @(negedge clk);
    check("en_progress", 32'(out_beats >= start + 10), 32'd1);
    enable = 1'b0;
    send(0, 8, 8'h10, 1'b0);
    wait_idle(2000, 0);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("en_hold", 32'({busy, out_src_rdy, in0_dst_rdy}), 32'd0);
    end
    exp_pkt(0, 8, 8'h10, 1'b0);
    enable = 1'b1;
    wait_idle(1000, 1);
    check("final_trunc_count", 32'(trunc_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
